microwave_timer_fsm: RTL and testbench
======================================

Name: microwave_timer_fsm

Overview:
- Cook-timer controller between the three debounced button levels (BTNC/BTNU/BTND) and the FND display path.
- Holds the remaining cook time in seconds and counts it down at 1 Hz while running.
- Drives the motor-enable `o_run` and a one-hot `o_state`. `o_state[3]` (DONE) selects the finish animation.
- Returns to IDLE when the finish-display stage pulses `finish`.

Parameters:
- CLK_HZ, 100_000_000, clk cycles per second tick (prescaler terminal count).
- STEP_SEC, 10, seconds added or removed per BTNU/BTND press.
- MAX_SEC, 999, saturation limit of the time value.
- AUTO_CLEAR_SEC, 5, seconds in DONE before automatic exit (used only with MW_AUTO_CLEAR_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- BTNC  input  1  debounced start/pause level.
- BTNU  input  1  debounced add-time level.
- BTND  input  1  debounced subtract-time level.
- finish  input  1  one-clk pulse from finish display: animation complete.
- o_sec  output  $clog2(1000)+1 (11)  remaining seconds, binary, to FND_CTRL count_data.
- o_run  output  1  motor enable, high only in RUN.
- o_state  output  4  one-hot: 0001 IDLE, 0010 RUN, 0100 PAUSE, 1000 DONE.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE; o_state=0001, o_sec=0, o_run=0; prescaler=0.
  - Button history registers=1, so a button held through reset release does not fire.
- Edge detect: press = level high this cycle and history low. History is updated every clk. All outputs are registered; effect is visible on the clk edge after the press cycle (latency 1).
- Prescaler: counts 0..CLK_HZ-1 only in RUN. tick=1 on the terminal count, then wraps to 0.
  - Holds its value in PAUSE.
  - Cleared on every IDLE->RUN transition.
- IDLE:
  - BTNU: o_sec = min(o_sec+STEP_SEC, MAX_SEC).
  - BTND: o_sec = max(o_sec-STEP_SEC, 0), computed without underflow.
  - BTNC with o_sec>0 -> RUN. BTNC with o_sec=0 -> stay IDLE.
- RUN:
  - o_run=1.
  - tick: o_sec decrements by 1; if o_sec was 1 -> o_sec=0, state DONE in the same edge.
  - BTNU adds STEP_SEC with saturation; if a tick coincides, the add applies after the decrement (one update per cycle).
  - BTND is ignored.
  - BTNC -> PAUSE.
- PAUSE:
  - o_run=0.
  - BTNU/BTND adjust as in IDLE.
  - BTNC with o_sec>0 -> RUN (prescaler resumes). BTND reaching 0 -> IDLE.
- Cancel: BTNC and BTND pressed in the same cycle, in any state except DONE -> IDLE, o_sec=0. Cancel has priority over all other rules.
- DONE:
  - o_run=0, o_sec=0; all buttons ignored.
  - finish=1 -> IDLE.
  - finish is ignored in every other state.
- Priority for simultaneous presses (non-cancel): BTNC > BTNU > BTND; only the highest-priority press acts.
- Reset mid-RUN: motor off immediately (async); time is lost.

Optional Feature:
- Macro MW_AUTO_CLEAR_EN.
- Defined: a second-counter runs in DONE using the same prescaler (cleared on DONE entry).
  - After AUTO_CLEAR_SEC ticks, state -> IDLE even with no finish.
  - finish still exits earlier.
- Undefined: DONE persists until finish; the counter logic is not compiled.

Test Plan:
- Set and start:
  - Stimulus: CLK_HZ=10, reset, 3 BTNU presses.
  - Required: o_sec=30, o_state=0001.
  - Then BTNC: o_state=0010 and o_run=1 one clk later; o_sec=29 after 10 clks in RUN.
- Saturation and floor:
  - MAX_SEC=25: three BTNU presses -> 25.
  - Three BTND presses -> 15, 5, 0; no wrap to 2047.
  - BTNC at 0 -> remains IDLE.
- Pause and resume:
  - Stimulus: run from 20, BTNC after 15 clks.
  - Required: PAUSE with o_sec=19, o_run=0.
  - Hold PAUSE 100 clks -> o_sec stays 19.
  - BTNC -> RUN; o_sec=18 after 5 more clks (prescaler held).
- Completion:
  - Stimulus: start at 10, run 100 clks.
  - Required: o_state=1000, o_sec=0, o_run=0.
  - Buttons ignored in DONE; finish pulse -> o_state=0001.
- Cancel and reset:
  - BTNC+BTND in the same cycle while RUN at 40 -> IDLE, o_sec=0.
  - Async reset asserted mid-RUN -> o_run=0 without waiting for clk.
  - BTNU held across reset release -> no increment.
- MW_AUTO_CLEAR_EN, AUTO_CLEAR_SEC=2, CLK_HZ=10:
  - DONE with no finish -> IDLE after 20 clks.
  - Without the macro: still DONE at 1000 clks.

Source files
------------

// File: rtl/microwave_timer_fsm.sv
// Microwave cook-timer controller: button edge detect, 1 Hz countdown, one-hot state output.
// Optional MW_AUTO_CLEAR_EN: leave DONE automatically after AUTO_CLEAR_SEC seconds.
module microwave_timer_fsm #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned STEP_SEC       = 10,
  parameter int unsigned MAX_SEC        = 999,
  parameter int unsigned AUTO_CLEAR_SEC = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  BTNC,
  input  logic                  BTNU,
  input  logic                  BTND,
  input  logic                  finish,
  output logic [$clog2(1000):0] o_sec,
  output logic                  o_run,
  output logic [3:0]            o_state
);

  localparam int SEC_W = $clog2(1000) + 1;
  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] STEP     = SEC_W'(STEP_SEC);
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(MAX_SEC);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_PAUSE = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d, sec_run;
  logic             run_q, run_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [2:0]       btn_hist_q;   // {C, U, D}
  logic             press_c, press_u, press_d;
  logic             cancel, tick;

`ifdef MW_AUTO_CLEAR_EN
  localparam int AUTO_W = (AUTO_CLEAR_SEC > 1) ? $clog2(AUTO_CLEAR_SEC) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CLEAR_SEC - 1);
  logic [AUTO_W-1:0] auto_q, auto_d;
`else
  logic unused_auto_clear;
  assign unused_auto_clear = |AUTO_CLEAR_SEC;
`endif

  function automatic logic [SEC_W-1:0] sat_add(input logic [SEC_W-1:0] v);
    logic [SEC_W:0] sum;
    sum = {1'b0, v} + {1'b0, STEP};
    return (sum >= {1'b0, SEC_MAX}) ? SEC_MAX : sum[SEC_W-1:0];
  endfunction

  function automatic logic [SEC_W-1:0] sat_sub(input logic [SEC_W-1:0] v);
    return (v > STEP) ? (v - STEP) : '0;
  endfunction

  assign press_c = BTNC & ~btn_hist_q[2];
  assign press_u = BTNU & ~btn_hist_q[1];
  assign press_d = BTND & ~btn_hist_q[0];
  assign cancel  = press_c & press_d;
  assign tick    = (presc_q == PRE_LAST);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    sec_run = sec_q;
`ifdef MW_AUTO_CLEAR_EN
    auto_d  = '0;
`endif
    if (cancel && state_q != ST_DONE) begin
      state_d = ST_IDLE;
      sec_d   = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (press_c) begin
            if (sec_q != '0) state_d = ST_RUN;
          end else if (press_u) begin
            sec_d = sat_add(sec_q);
          end else if (press_d) begin
            sec_d = sat_sub(sec_q);
          end
        end

        ST_RUN: begin
          presc_d = tick ? '0 : presc_q + PRE_W'(1);
          if (tick) sec_run = sec_q - SEC_W'(1);
          // Reaching zero outranks any button press landing in the same cycle.
          if (tick && sec_q <= SEC_W'(1)) begin
            state_d = ST_DONE;
            sec_d   = '0;
            presc_d = '0;
          end else if (press_c) begin
            state_d = ST_PAUSE;
            sec_d   = sec_run;
          end else if (press_u) begin
            sec_d = sat_add(sec_run);
          end else begin
            sec_d = sec_run;
          end
        end

        ST_PAUSE: begin
          if (press_c) begin
            if (sec_q != '0) state_d = ST_RUN;
          end else if (press_u) begin
            sec_d = sat_add(sec_q);
          end else if (press_d) begin
            sec_d = sat_sub(sec_q);
            if (sat_sub(sec_q) == '0) begin
              state_d = ST_IDLE;
              presc_d = '0;
            end
          end
        end

        ST_DONE: begin
          sec_d   = '0;
          presc_d = '0;
          if (finish) begin
            state_d = ST_IDLE;
          end
`ifdef MW_AUTO_CLEAR_EN
          else begin
            presc_d = tick ? '0 : presc_q + PRE_W'(1);
            auto_d  = auto_q;
            if (tick) begin
              if (auto_q == AUTO_LAST) state_d = ST_IDLE;
              else                     auto_d  = auto_q + AUTO_W'(1);
            end
          end
`endif
        end

        default: begin
          state_d = ST_IDLE;
          sec_d   = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  assign run_d = (state_d == ST_RUN);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sec_q      <= '0;
      run_q      <= 1'b0;
      presc_q    <= '0;
      // NOTE: history resets high so a button already held at reset release is not seen as a press.
      btn_hist_q <= 3'b111;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      run_q      <= run_d;
      presc_q    <= presc_d;
      btn_hist_q <= {BTNC, BTNU, BTND};
    end
  end

`ifdef MW_AUTO_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) auto_q <= '0;
    else       auto_q <= auto_d;
  end
`endif

  assign o_state = state_q;
  assign o_sec   = sec_q;
  assign o_run   = run_q;

endmodule

// File: tb/tb_microwave_timer_fsm.sv
// Directed table-driven bench for microwave_timer_fsm (CLK_HZ=10 so one second is ten clocks).
module tb_microwave_timer_fsm;

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_RUN   = 4'b0010;
  localparam logic [3:0] S_PAUSE = 4'b0100;
  localparam logic [3:0] S_DONE  = 4'b1000;

  // One vector: drive the press pattern for one clock, idle 'extra' clocks, then compare.
  typedef struct {
    bit          c;
    bit          u;
    bit          d;
    bit          fin;
    int          extra;
    logic [10:0] sec;
    logic [3:0]  st;
    bit          run;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        BTNC, BTNU, BTND, finish;
  logic [10:0] sec, sat_sec;
  logic        run, sat_run;
  logic [3:0]  st, sat_st;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sat_q[$];
  vec_t main_q[$];

  always #5 clk = ~clk;

  microwave_timer_fsm #(.CLK_HZ(10), .STEP_SEC(10), .MAX_SEC(999), .AUTO_CLEAR_SEC(2)) u_dut (
    .clk(clk), .reset(reset), .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND), .finish(finish),
    .o_sec(sec), .o_run(run), .o_state(st)
  );

  microwave_timer_fsm #(.CLK_HZ(10), .STEP_SEC(10), .MAX_SEC(25), .AUTO_CLEAR_SEC(2)) u_sat (
    .clk(clk), .reset(reset), .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND), .finish(finish),
    .o_sec(sat_sec), .o_run(sat_run), .o_state(sat_st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit c, input bit u, input bit d, input bit fin, input int extra,
                              input logic [10:0] s, input logic [3:0] state, input bit r);
    vec_t v;
    v.c = c; v.u = u; v.d = d; v.fin = fin; v.extra = extra;
    v.sec = s; v.st = state; v.run = r;
    return v;
  endfunction

  task automatic apply(input string tag, input int idx, input vec_t v, input bit use_sat);
    BTNC = v.c; BTNU = v.u; BTND = v.d; finish = v.fin;
    @(negedge clk);
    BTNC = 1'b0; BTNU = 1'b0; BTND = 1'b0; finish = 1'b0;
    repeat (v.extra) @(negedge clk);
    if (use_sat) begin
      check($sformatf("%s[%0d].sec", tag, idx),   32'(sat_sec), 32'(v.sec));
      check($sformatf("%s[%0d].state", tag, idx), 32'(sat_st),  32'(v.st));
      check($sformatf("%s[%0d].run", tag, idx),   32'(sat_run), 32'(v.run));
    end else begin
      check($sformatf("%s[%0d].sec", tag, idx),   32'(sec), 32'(v.sec));
      check($sformatf("%s[%0d].state", tag, idx), 32'(st),  32'(v.st));
      check($sformatf("%s[%0d].run", tag, idx),   32'(run), 32'(v.run));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Saturation/floor on the MAX_SEC=25 instance.
    sat_q.push_back(mk(0,1,0,0, 1, 11'd10, S_IDLE, 0));
    sat_q.push_back(mk(0,1,0,0, 1, 11'd20, S_IDLE, 0));
    sat_q.push_back(mk(0,1,0,0, 1, 11'd25, S_IDLE, 0));
    sat_q.push_back(mk(0,0,1,0, 1, 11'd15, S_IDLE, 0));
    sat_q.push_back(mk(0,0,1,0, 1, 11'd5,  S_IDLE, 0));
    sat_q.push_back(mk(0,0,1,0, 1, 11'd0,  S_IDLE, 0));
    sat_q.push_back(mk(1,0,0,0, 1, 11'd0,  S_IDLE, 0));

    // Set and start, finish/BTND ignored in RUN, add in RUN, cancel.
    main_q.push_back(mk(0,1,0,0, 1, 11'd10, S_IDLE, 0));
    main_q.push_back(mk(0,1,0,0, 1, 11'd20, S_IDLE, 0));
    main_q.push_back(mk(0,1,0,0, 1, 11'd30, S_IDLE, 0));
    main_q.push_back(mk(1,0,0,0, 0, 11'd30, S_RUN,  1));
    main_q.push_back(mk(0,0,0,0, 8, 11'd30, S_RUN,  1));
    main_q.push_back(mk(0,0,0,0, 0, 11'd29, S_RUN,  1));
    main_q.push_back(mk(0,0,0,1, 0, 11'd29, S_RUN,  1));
    main_q.push_back(mk(0,0,1,0, 1, 11'd29, S_RUN,  1));
    main_q.push_back(mk(0,1,0,0, 1, 11'd39, S_RUN,  1));
    main_q.push_back(mk(1,0,1,0, 1, 11'd0,  S_IDLE, 0));
    // Cancel while running at 40.
    main_q.push_back(mk(0,1,0,0, 1, 11'd10, S_IDLE, 0));
    main_q.push_back(mk(0,1,0,0, 1, 11'd20, S_IDLE, 0));
    main_q.push_back(mk(0,1,0,0, 1, 11'd30, S_IDLE, 0));
    main_q.push_back(mk(0,1,0,0, 1, 11'd40, S_IDLE, 0));
    main_q.push_back(mk(1,0,0,0, 1, 11'd40, S_RUN,  1));
    main_q.push_back(mk(1,0,1,0, 1, 11'd0,  S_IDLE, 0));
    // Pause and resume from 20; prescaler held through PAUSE; adjust in PAUSE down to IDLE.
    main_q.push_back(mk(0,1,0,0, 1,  11'd10, S_IDLE,  0));
    main_q.push_back(mk(0,1,0,0, 1,  11'd20, S_IDLE,  0));
    main_q.push_back(mk(1,0,0,0, 0,  11'd20, S_RUN,   1));
    main_q.push_back(mk(0,0,0,0, 13, 11'd19, S_RUN,   1));
    main_q.push_back(mk(1,0,0,0, 0,  11'd19, S_PAUSE, 0));
    main_q.push_back(mk(0,0,0,0, 99, 11'd19, S_PAUSE, 0));
    main_q.push_back(mk(1,0,0,0, 0,  11'd19, S_RUN,   1));
    main_q.push_back(mk(0,0,0,0, 3,  11'd19, S_RUN,   1));
    main_q.push_back(mk(0,0,0,0, 0,  11'd18, S_RUN,   1));
    main_q.push_back(mk(1,0,0,0, 1,  11'd18, S_PAUSE, 0));
    main_q.push_back(mk(0,1,0,0, 1,  11'd28, S_PAUSE, 0));
    main_q.push_back(mk(0,0,1,0, 1,  11'd18, S_PAUSE, 0));
    main_q.push_back(mk(0,0,1,0, 1,  11'd8,  S_PAUSE, 0));
    main_q.push_back(mk(0,0,1,0, 1,  11'd0,  S_IDLE,  0));
    // Completion from 10, buttons and cancel ignored in DONE, finish returns to IDLE.
    main_q.push_back(mk(0,1,0,0, 1,  11'd10, S_IDLE, 0));
    main_q.push_back(mk(1,0,0,0, 0,  11'd10, S_RUN,  1));
    main_q.push_back(mk(0,0,0,0, 98, 11'd1,  S_RUN,  1));
    main_q.push_back(mk(0,0,0,0, 0,  11'd0,  S_DONE, 0));
    main_q.push_back(mk(0,1,0,0, 1,  11'd0,  S_DONE, 0));
    main_q.push_back(mk(1,0,0,0, 1,  11'd0,  S_DONE, 0));
    main_q.push_back(mk(1,0,1,0, 1,  11'd0,  S_DONE, 0));
    main_q.push_back(mk(0,0,0,1, 0,  11'd0,  S_IDLE, 0));

    reset = 1'b1; BTNC = 1'b0; BTNU = 1'b0; BTND = 1'b0; finish = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.sec",   32'(sec), 32'd0);
    check("reset.state", 32'(st),  32'(S_IDLE));
    check("reset.run",   32'(run), 32'd0);

    foreach (sat_q[i])  apply("sat",  i, sat_q[i], 1'b1);
    foreach (main_q[i]) apply("main", i, main_q[i], 1'b0);

    // DONE residency: auto-exit after two seconds with the option, otherwise held until finish.
    apply("done", 0, mk(0,1,0,0, 1,  11'd10, S_IDLE, 0), 1'b0);
    apply("done", 1, mk(1,0,0,0, 0,  11'd10, S_RUN,  1), 1'b0);
    apply("done", 2, mk(0,0,0,0, 99, 11'd0,  S_DONE, 0), 1'b0);
`ifdef MW_AUTO_CLEAR_EN
    apply("done", 3, mk(0,0,0,0, 18, 11'd0,  S_DONE, 0), 1'b0);
    apply("done", 4, mk(0,0,0,0, 0,  11'd0,  S_IDLE, 0), 1'b0);
`else
    apply("done", 3, mk(0,0,0,0, 999, 11'd0, S_DONE, 0), 1'b0);
    apply("done", 4, mk(0,0,0,1, 0,   11'd0, S_IDLE, 0), 1'b0);
`endif

    // Async reset mid-RUN, then BTNU held across reset release.
    apply("arst", 0, mk(0,1,0,0, 1, 11'd10, S_IDLE, 0), 1'b0);
    apply("arst", 1, mk(1,0,0,0, 0, 11'd10, S_RUN,  1), 1'b0);
    apply("arst", 2, mk(0,0,0,0, 4, 11'd10, S_RUN,  1), 1'b0);
    #1 reset = 1'b1;
    #1;
    check("arst.run",   32'(run), 32'd0);
    check("arst.state", 32'(st),  32'(S_IDLE));
    check("arst.sec",   32'(sec), 32'd0);
    BTNU = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("held.sec",   32'(sec), 32'd0);
    check("held.state", 32'(st),  32'(S_IDLE));
    BTNU = 1'b0;
    @(negedge clk);
    check("held.release.sec", 32'(sec), 32'd0);
    apply("held", 0, mk(0,1,0,0, 1, 11'd10, S_IDLE, 0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
